threshold_classifier: RTL and testbench

//  Registered, parametrised successor to the 3-bit X/Y decoder.
//  - x_out: "high" flag with hysteresis and debounce, driven by a 4-state FSM.
//  - y_out: registered "zero" flag.
//  - cross_cnt: saturating count of debounced rising crossings.

---
 rtl/threshold_classifier.sv | 90 +++++++++
 tb/tb_threshold_classifier.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/threshold_classifier.sv
// threshold_classifier: debounced high flag with hysteresis, registered zero flag, saturating crossing counter
module threshold_classifier #(
  parameter int WIDTH  = 3,
  parameter int HI_ON  = 5,
  parameter int HI_OFF = 4,
  parameter int STABLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_val,
  input  logic             cnt_clr,
  output logic             x_out,
  output logic             y_out,
  output logic             x_rise,
  output logic [CNT_W-1:0] cross_cnt
);
  localparam int DW = $clog2(STABLE + 1);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [DW-1:0] D_STB = DW'(STABLE);
  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;
  state_t r_state, w_state_nx;
  logic [DW-1:0] r_dcnt, w_dcnt_nx, w_dcnt_inc;
  logic w_hi, w_lo, w_done, w_enter_high;
  logic r_y, r_rise;
  logic [CNT_W-1:0] r_cnt;
  assign w_hi = 32'(in_val) >= HI_ON;
  assign w_lo = 32'(in_val) < HI_OFF;
  assign w_dcnt_inc = r_dcnt + D_ONE;
  assign w_done = w_dcnt_inc == D_STB;
  always_comb begin
    w_state_nx = r_state;
    w_dcnt_nx = r_dcnt;
    if (in_valid)
      case (r_state)
        LOW: if (w_hi) begin
          if (STABLE == 1) w_state_nx = HIGH;
          else begin
            w_state_nx = RISE;
            w_dcnt_nx = D_ONE;
          end
        end
        RISE: begin
          w_dcnt_nx = w_hi && !w_done ? w_dcnt_inc : '0;
          if (!w_hi) w_state_nx = LOW;
          else if (w_done) w_state_nx = HIGH;
        end
        HIGH: if (w_lo) begin
          if (STABLE == 1) w_state_nx = LOW;
          else begin
            w_state_nx = FALL;
            w_dcnt_nx = D_ONE;
          end
        end
        default: begin
          w_dcnt_nx = w_lo && !w_done ? w_dcnt_inc : '0;
          if (!w_lo) w_state_nx = HIGH;
          else if (w_done) w_state_nx = LOW;
        end
      endcase
  end
  // Only LOW/RISE -> HIGH counts as a crossing; FALL -> HIGH is an aborted fall.
  assign w_enter_high = (r_state == LOW || r_state == RISE) && w_state_nx == HIGH;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOW;
      r_dcnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_dcnt <= w_dcnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y <= 1'b0;
      r_rise <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (in_valid) r_y <= in_val == '0;
      r_rise <= w_enter_high;
      r_cnt <= w_enter_high ? (cnt_clr ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + CNT_W'(1)))
                            : (cnt_clr ? '0 : r_cnt);
    end
  end
  assign x_out = r_state == HIGH || r_state == FALL;
  assign y_out = r_y;
  assign x_rise = r_rise;
  assign cross_cnt = r_cnt;
endmodule

// File: tb/tb_threshold_classifier.sv
// tb_threshold_classifier: directed and random checks of three parameterisations against a run-length model
module tb_threshold_classifier;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, v, clr, vc, clrc;
  logic [2:0] val;
  logic [7:0] valc;
  logic xa, ya, ra, xb, yb, rb, xc, yc, rc;
  logic [7:0] ca, cc;
  logic [1:0] cb;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {int x; int run; int y; int rise; int cnt;} mdl_t;
  mdl_t ma, mb, mc;
  threshold_classifier u_a (.clk(clk), .rst_n(rst_n), .in_valid(v), .in_val(val), .cnt_clr(clr),
                            .x_out(xa), .y_out(ya), .x_rise(ra), .cross_cnt(ca));
  threshold_classifier #(.CNT_W(2)) u_b (.clk(clk), .rst_n(rst_n), .in_valid(v), .in_val(val), .cnt_clr(clr),
                            .x_out(xb), .y_out(yb), .x_rise(rb), .cross_cnt(cb));
  threshold_classifier #(.WIDTH(8), .HI_ON(200), .HI_OFF(100), .STABLE(1)) u_c (.clk(clk), .rst_n(rst_n),
                            .in_valid(vc), .in_val(valc), .cnt_clr(clrc),
                            .x_out(xc), .y_out(yc), .x_rise(rc), .cross_cnt(cc));
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // x flips once STABLE consecutive valid samples lie on the far side of its current threshold.
  function automatic mdl_t step(mdl_t m, bit rs, bit vv, int s, bit cl, int on, int off, int stb, int cmax);
    mdl_t n;
    n = m;
    n.rise = 0;
    if (!rs) begin
      n = '{0, 0, 0, 0, 0};
      return n;
    end
    if (vv) begin
      n.y = s == 0 ? 1 : 0;
      if (m.x == 0 ? s >= on : s < off) begin
        n.run = m.run + 1;
        if (n.run == stb) begin
          n.x = 1 - m.x;
          n.run = 0;
          n.rise = n.x;
        end
      end else n.run = 0;
    end
    if (cl) n.cnt = 0;
    if (n.rise == 1) n.cnt = cl ? 1 : (m.cnt == cmax ? cmax : m.cnt + 1);
    return n;
  endfunction
  task automatic cycle();
    @(posedge clk);
    ma = step(ma, rst_n, v, int'(val), clr, 5, 4, 2, 255);
    mb = step(mb, rst_n, v, int'(val), clr, 5, 4, 2, 3);
    mc = step(mc, rst_n, vc, int'(valc), clrc, 200, 100, 1, 255);
    @(negedge clk);
    check("a_x", int'(xa), ma.x);
    check("a_y", int'(ya), ma.y);
    check("a_rise", int'(ra), ma.rise);
    check("a_cnt", int'(ca), ma.cnt);
    check("b_x", int'(xb), mb.x);
    check("b_cnt", int'(cb), mb.cnt);
    check("c_x", int'(xc), mc.x);
    check("c_y", int'(yc), mc.y);
    check("c_rise", int'(rc), mc.rise);
    check("c_cnt", int'(cc), mc.cnt);
  endtask
  task automatic put(input bit vv, input int s);
    v = vv;
    val = 3'(s);
    cycle();
  endtask
  initial begin
    ma = '{0, 0, 0, 0, 0};
    mb = ma;
    mc = ma;
    rst_n = 1'b0; v = 1'b1; val = 3'd7; clr = 1'b0;
    vc = 1'b1; valc = 8'd255; clrc = 1'b0;
    cycle();
    cycle();
    check("rst_x", int'(xa), 0);
    check("rst_cnt", int'(ca), 0);
    check("rst_xc", int'(xc), 0);
    vc = 1'b0;
    rst_n = 1'b1;
    put(1, 5);
    rst_n = 1'b0;
    put(1, 6);
    rst_n = 1'b1;
    put(1, 6);
    check("rst_mid_rise", int'(xa), 0);
    put(0, 0);
    put(1, 0);
    put(1, 5);
    put(1, 6);
    check("deb_x", int'(xa), 1);
    check("deb_rise", int'(ra), 1);
    check("deb_cnt", int'(ca), 1);
    put(0, 0);
    check("rise_pulse_end", int'(ra), 0);
    put(1, 0); put(1, 0);
    put(1, 5); put(1, 3); put(1, 5);
    check("deb_abort", int'(xa), 0);
    put(1, 6);
    put(1, 4); put(1, 4); put(1, 4);
    check("hyst_band", int'(xa), 1);
    put(1, 3); put(1, 2);
    check("hyst_fall", int'(xa), 0);
    put(1, 5); put(1, 5);
    put(1, 3); put(1, 4); put(1, 3);
    check("fall_abort", int'(xa), 1);
    put(1, 0); put(1, 0);
    put(1, 5); put(0, 0); put(0, 0); put(0, 0); put(1, 6);
    check("gap_deb", int'(xa), 1);
    put(1, 0);
    put(0, 3);
    check("y_hold", int'(ya), 1);
    check("b_sat", int'(cb), 3);
    put(1, 0); put(1, 0);
    put(1, 5);
    clr = 1'b1;
    put(1, 7);
    clr = 1'b0;
    check("clr_rise_a", int'(ca), 1);
    check("clr_rise_b", int'(cb), 1);
    v = 1'b0;
    vc = 1'b1; valc = 8'd200;
    cycle();
    check("s1_hi", int'(xc), 1);
    valc = 8'd99;
    cycle();
    check("s1_lo", int'(xc), 0);
    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom % 500) != 0;
      v = ($urandom % 4) != 0;
      val = 3'($urandom);
      clr = ($urandom % 40) == 0;
      vc = ($urandom % 4) != 0;
      valc = 8'($urandom);
      clrc = ($urandom % 40) == 0;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
